hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage integer core, placed between IF/ID, ID/EX, EX/MEM and MEM/WB. It detects load-use data hazards and generates the stall and bubble controls. It also handles taken-branch flushes and selects EX-stage operand forwarding. Optional registered counters report stall and flush activity.

---
 rtl/hazard_unit.sv | 97 +++++++++
 tb/tb_hazard_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Load-use stall, taken-branch flush and EX operand forwarding for the five-stage core.
// Define HAZARD_UNIT_STATS_EN to add saturating stall/flush event counters.
module hazard_unit (
  input  logic       clk             = 1'b0,
  input  logic       rst             = 1'b0,
  input  logic       id_ex_memRead,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       ex_branch_taken = 1'b0,
  input  logic [4:0] id_ex_rs1       = 5'd0,
  input  logic [4:0] id_ex_rs2       = 5'd0,
  input  logic       ex_mem_regWrite = 1'b0,
  input  logic [4:0] ex_mem_rd       = 5'd0,
  input  logic       mem_wb_regWrite = 1'b0,
  input  logic [4:0] mem_wb_rd       = 5'd0,
  output logic       stall,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_flush,
  output logic       if_id_flush,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
`ifdef HAZARD_UNIT_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  logic load_use;

  assign load_use = id_ex_memRead && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  // A taken branch squashes the younger instructions, so the load-use stall is moot.
  always_comb begin
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_flush = 1'b0;
    if_id_flush = 1'b0;
    if (ex_branch_taken) begin
      id_ex_flush = 1'b1;
      if_id_flush = 1'b1;
    end else if (load_use) begin
      stall       = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_regWrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs))
      return 2'b10;
    else if (mem_wb_regWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign forward_a = fwd_sel(id_ex_rs1);
  assign forward_b = fwd_sel(id_ex_rs2);

`ifdef HAZARD_UNIT_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counters hold at all-ones rather than wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
    if (if_id_flush && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized self-checking bench for hazard_unit against a rule-level reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_ex_memRead;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic       ex_branch_taken;
  logic [4:0] id_ex_rs1, id_ex_rs2;
  logic       ex_mem_regWrite;
  logic [4:0] ex_mem_rd;
  logic       mem_wb_regWrite;
  logic [4:0] mem_wb_rd;
  logic       stall, pc_write, if_id_write, id_ex_flush, if_id_flush;
  logic [1:0] forward_a, forward_b;
`ifdef HAZARD_UNIT_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .id_ex_memRead(id_ex_memRead), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .ex_branch_taken(ex_branch_taken),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .ex_mem_regWrite(ex_mem_regWrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .forward_a(forward_a), .forward_b(forward_b)
`ifdef HAZARD_UNIT_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // Reference model: expected outputs packed as
  // {stall, pc_write, if_id_write, id_ex_flush, if_id_flush, fwd_a[1:0], fwd_b[1:0]}
  function automatic logic [8:0] model();
    bit hazard, kill, stop;
    int fa, fb;
    hazard = id_ex_memRead && id_ex_rd != 0 &&
             (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    kill = ex_branch_taken;
    stop = hazard && !kill;
    fa = 0;
    fb = 0;
    if (mem_wb_regWrite && mem_wb_rd != 0) begin
      if (mem_wb_rd == id_ex_rs1) fa = 1;
      if (mem_wb_rd == id_ex_rs2) fb = 1;
    end
    if (ex_mem_regWrite && ex_mem_rd != 0) begin
      if (ex_mem_rd == id_ex_rs1) fa = 2;
      if (ex_mem_rd == id_ex_rs2) fb = 2;
    end
    return {stop, !stop, !stop, (kill || hazard), kill, 2'(fa), 2'(fb)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {stall, pc_write, if_id_write, id_ex_flush, if_id_flush, forward_a, forward_b};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_ex_memRead = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    ex_branch_taken = 0; id_ex_rs1 = 0; id_ex_rs2 = 0;
    ex_mem_regWrite = 0; ex_mem_rd = 0; mem_wb_regWrite = 0; mem_wb_rd = 0;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [8:0] e, g;
      e = model();
      g = dut_vec();
      check("hazard_vec", 32'(g), 32'(e));
      $display("cyc t=%0t ld=%0b rd=%0d rs=%0d/%0d br=%0b -> %b (model %b)",
               $time, id_ex_memRead, id_ex_rd, if_id_rs1, if_id_rs2,
               ex_branch_taken, g, e);
    end
  end

`ifdef HAZARD_UNIT_STATS_EN
  longint m_stall = 0, m_flush = 0;
  bit cnt_valid = 0;
  always @(posedge clk) begin
    logic [8:0] e;
    e = model();
    if (rst) begin
      m_stall = 0; m_flush = 0; cnt_valid = 1;
    end else begin
      if (e[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e[4] && m_flush < 64'hFFFF_FFFF) m_flush++;
    end
  end
  always @(negedge clk) begin
    if (cmp_en && cnt_valid) begin
      check("stall_count", stall_count, 32'(m_stall));
      check("flush_count", flush_count, 32'(m_flush));
    end
  end
`endif

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    cmp_en = 1;

    // Hand-computed cases; each checks DUT and model against literals.
    clear_inputs(); id_ex_rd = 3; if_id_rs1 = 1; if_id_rs2 = 2; #1;
    check("no_haz_dut", 32'(dut_vec()), 32'b0_1_1_0_0_00_00);
    check("no_haz_model", 32'(model()), 32'b0_1_1_0_0_00_00);
    tick();
    id_ex_memRead = 1; id_ex_rd = 1; if_id_rs1 = 1; if_id_rs2 = 9; #1;
    check("lu_rs1_dut", 32'(dut_vec()), 32'b1_0_0_1_0_00_00);
    check("lu_rs1_model", 32'(model()), 32'b1_0_0_1_0_00_00);
    tick();
    id_ex_rd = 2; if_id_rs1 = 10; if_id_rs2 = 2; #1;
    check("lu_rs2_dut", 32'(dut_vec()), 32'b1_0_0_1_0_00_00);
    tick();
    id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0; #1;
    check("x0_dut", 32'(dut_vec()), 32'b0_1_1_0_0_00_00);
    check("x0_model", 32'(model()), 32'b0_1_1_0_0_00_00);
    tick();
    id_ex_rd = 4; if_id_rs1 = 4; ex_branch_taken = 1; #1;
    check("br_prio_dut", 32'(dut_vec()), 32'b0_1_1_1_1_00_00);
    check("br_prio_model", 32'(model()), 32'b0_1_1_1_1_00_00);
    tick();
    clear_inputs();
    ex_mem_rd = 5; mem_wb_rd = 5; ex_mem_regWrite = 1; mem_wb_regWrite = 1;
    id_ex_rs1 = 5; id_ex_rs2 = 5; #1;
    check("fwd_exmem_a", 32'(forward_a), 32'd2);
    check("fwd_exmem_b", 32'(forward_b), 32'd2);
    tick();
    ex_mem_regWrite = 0; #1;
    check("fwd_memwb_a", 32'(forward_a), 32'd1);
    check("fwd_memwb_b", 32'(forward_b), 32'd1);
    tick();
    ex_mem_regWrite = 1; ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs1 = 0; id_ex_rs2 = 0; #1;
    check("fwd_x0_a", 32'(forward_a), 32'd0);
    check("fwd_x0_b", 32'(forward_b), 32'd0);
    check("fwd_x0_model", 32'(model()), 32'b0_1_1_0_0_00_00);
    tick();
    clear_inputs();

`ifdef HAZARD_UNIT_STATS_EN
    rst = 1;
    tick();
    rst = 0;
    id_ex_memRead = 1; id_ex_rd = 7; if_id_rs1 = 7;
    tick(); tick(); tick();
    clear_inputs(); ex_branch_taken = 1;
    tick(); tick();
    clear_inputs();
    tick();
    check("stall_cnt_lit", stall_count, 32'd3);
    check("flush_cnt_lit", flush_count, 32'd2);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("stall_cnt_rst", stall_count, 32'd0);
    check("flush_cnt_rst", flush_count, 32'd0);
`endif

    // Randomized phase with a narrow register range to make matches frequent.
    for (int i = 0; i < 400; i++) begin
      tick();
      rst             = ($urandom_range(0, 31) == 0);
      id_ex_memRead   = 1'($urandom);
      id_ex_rd        = 5'($urandom_range(0, 3));
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      id_ex_rs1       = 5'($urandom_range(0, 3));
      id_ex_rs2       = 5'($urandom_range(0, 3));
      ex_mem_regWrite = 1'($urandom);
      ex_mem_rd       = 5'($urandom_range(0, 3));
      mem_wb_regWrite = 1'($urandom);
      mem_wb_rd       = 5'($urandom_range(0, 3));
    end
    tick();
    rst = 0;
    tick();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
